// File: rtl/hazard_pkg.sv
// Shared definitions for the decode-stage hazard detector.
//   REG_ADDR_W     : default architectural register index width (32 GPRs, x0 = zero)
//   stall_cause_t  : encoding of the stall_cause output, in decreasing priority
//                    order: load-use > mul/div RAW > mul/div structural.
package hazard_pkg;

  localparam int unsigned REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    CAUSE_NONE      = 2'b00,
    CAUSE_LOAD_USE  = 2'b01,
    CAUSE_MD_RAW    = 2'b10,
    CAUSE_MD_STRUCT = 2'b11
  } stall_cause_t;

endpackage

// File: rtl/hazard_detect_md_scoreboard.sv
// md_scoreboard: tracks the single outstanding multi-cycle mul/div result.
//   clk, reset               : clock, synchronous active-high reset
//   md_issue, md_rd          : op accepted by the mul/div unit and its destination
//   md_done                  : result written back this cycle
//   id_rs1/2, id_rs1/2_used  : decode-stage source operands
//   md_busy                  : a tracked result is outstanding (registered)
//   md_pending               : outstanding and not being written back this cycle
//   raw_hit                  : a used ID source matches the pending destination
// Issue with md_rd == 0 is not tracked since the result is discarded.
// Issue and done in the same cycle: the new op's tag replaces the old one.
module md_scoreboard
  import hazard_pkg::*;
#(
  parameter int unsigned ADDR_W = hazard_pkg::REG_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              md_issue,
  input  logic [ADDR_W-1:0] md_rd,
  input  logic              md_done,
  input  logic [ADDR_W-1:0] id_rs1,
  input  logic [ADDR_W-1:0] id_rs2,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  output logic              md_busy,
  output logic              md_pending,
  output logic              raw_hit
);

  logic [ADDR_W-1:0] md_tag;
  logic              busy_next;
  logic [ADDR_W-1:0] tag_next;
  logic              hit1;
  logic              hit2;

  always_comb begin
    busy_next = md_busy;
    tag_next  = md_tag;
    if (md_issue && (md_rd != '0)) begin
      busy_next = 1'b1;
      tag_next  = md_rd;
    end else if (md_done) begin
      busy_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      md_busy <= 1'b0;
      md_tag  <= '0;
    end else begin
      md_busy <= busy_next;
      md_tag  <= tag_next;
    end
  end

  // A write-back in the current cycle reaches ID through the write-first
  // register file, so it no longer counts as pending.
  assign md_pending = md_busy & ~md_done;

  assign hit1    = id_rs1_used & (id_rs1 == md_tag) & (md_tag != '0);
  assign hit2    = id_rs2_used & (id_rs2 == md_tag) & (md_tag != '0);
  assign raw_hit = md_pending & (hit1 | hit2);

  // The structural stall must keep a second op from issuing while one is in flight.
  a_no_issue_while_pending : assert property (
    @(posedge clk) disable iff (reset) !(md_issue && md_busy && !md_done)
  );

endmodule

// File: rtl/hazard_detect.sv
// hazard_detect: decode-stage hazard detector, sole driver of stall_decode.
//   clk, reset          : clock, synchronous active-high reset
//   id_*                : decode-stage instruction (valid, sources, uses, is mul/div)
//   ex_valid/mem_read/rd: execute-stage instruction (load detection)
//   md_issue/md_rd      : mul/div issue from EX and its destination
//   md_done             : mul/div write-back this cycle
//   flush               : redirect, kills the ID instruction
//   stall_decode        : hold IF/ID
//   stall_cause         : 00 none, 01 load-use, 10 md RAW, 11 md structural
//   md_busy             : mul/div result outstanding
//   stall_cycles        : saturating stall-cycle counter
// Optional feature macro STALL_PERF_EN: when defined, stall_cycles counts cycles
// with stall_decode=1 and saturates at all-ones; otherwise it is tied to zero.
module hazard_detect
  import hazard_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = hazard_pkg::REG_ADDR_W,
  parameter int unsigned PERF_CNT_W = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_rs1_used,
  input  logic                  id_rs2_used,
  input  logic                  id_is_md,
  input  logic                  ex_valid,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  md_issue,
  input  logic [REG_ADDR_W-1:0] md_rd,
  input  logic                  md_done,
  input  logic                  flush,
  output logic                  stall_decode,
  output logic [1:0]            stall_cause,
  output logic                  md_busy,
  output logic [PERF_CNT_W-1:0] stall_cycles
);

  logic         live;
  logic         lu_hit1;
  logic         lu_hit2;
  logic         load_use;
  logic         md_pending;
  logic         raw_hit;
  stall_cause_t cause;

  md_scoreboard #(
    .ADDR_W (REG_ADDR_W)
  ) u_md_scoreboard (
    .clk         (clk),
    .reset       (reset),
    .md_issue    (md_issue),
    .md_rd       (md_rd),
    .md_done     (md_done),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_rs1_used (id_rs1_used),
    .id_rs2_used (id_rs2_used),
    .md_busy     (md_busy),
    .md_pending  (md_pending),
    .raw_hit     (raw_hit)
  );

  assign live = id_valid & ~flush;

  // x0 never carries a real dependency, so a load to x0 is exempt.
  assign lu_hit1  = id_rs1_used & (id_rs1 == ex_rd) & (ex_rd != '0);
  assign lu_hit2  = id_rs2_used & (id_rs2 == ex_rd) & (ex_rd != '0);
  assign load_use = ex_valid & ex_mem_read & (lu_hit1 | lu_hit2);

  always_comb begin
    cause = CAUSE_NONE;
    if (live) begin
      if (load_use) begin
        cause = CAUSE_LOAD_USE;
      end else if (raw_hit) begin
        cause = CAUSE_MD_RAW;
      end else if (id_is_md && md_pending) begin
        cause = CAUSE_MD_STRUCT;
      end
    end
  end

  assign stall_cause  = cause;
  assign stall_decode = |cause;

`ifdef STALL_PERF_EN
  logic [PERF_CNT_W-1:0] stall_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (stall_decode && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign stall_cycles = stall_cnt;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_hazard_detect.sv
module tb_hazard_detect;

  localparam int unsigned AW = 5;
  localparam int unsigned CW = 4;

  logic          clk;
  logic          reset;
  logic          id_valid;
  logic [AW-1:0] id_rs1;
  logic [AW-1:0] id_rs2;
  logic          id_rs1_used;
  logic          id_rs2_used;
  logic          id_is_md;
  logic          ex_valid;
  logic          ex_mem_read;
  logic [AW-1:0] ex_rd;
  logic          md_issue;
  logic [AW-1:0] md_rd;
  logic          md_done;
  logic          flush;
  logic          stall_decode;
  logic [1:0]    stall_cause;
  logic          md_busy;
  logic [CW-1:0] stall_cycles;

  hazard_detect #(
    .REG_ADDR_W (AW),
    .PERF_CNT_W (CW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .id_valid     (id_valid),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_rs1_used  (id_rs1_used),
    .id_rs2_used  (id_rs2_used),
    .id_is_md     (id_is_md),
    .ex_valid     (ex_valid),
    .ex_mem_read  (ex_mem_read),
    .ex_rd        (ex_rd),
    .md_issue     (md_issue),
    .md_rd        (md_rd),
    .md_done      (md_done),
    .flush        (flush),
    .stall_decode (stall_decode),
    .stall_cause  (stall_cause),
    .md_busy      (md_busy),
    .stall_cycles (stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string         name;
    logic          stall;
    logic [1:0]    cause;
    logic          busy;
    logic [CW-1:0] cycles;
  } exp_t;

  exp_t q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  logic [CW-1:0] exp_cnt = '0;

  // Monitor: each cycle with a pending expectation, compare the live outputs.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        e = q.pop_front();
        n_cmp++;
        if (stall_decode !== e.stall) begin
          n_fail++;
          $display("FAIL %s stall_decode: got %b want %b", e.name, stall_decode, e.stall);
        end
        n_cmp++;
        if (stall_cause !== e.cause) begin
          n_fail++;
          $display("FAIL %s stall_cause: got %b want %b", e.name, stall_cause, e.cause);
        end
        n_cmp++;
        if (md_busy !== e.busy) begin
          n_fail++;
          $display("FAIL %s md_busy: got %b want %b", e.name, md_busy, e.busy);
        end
        n_cmp++;
        if (stall_cycles !== e.cycles) begin
          n_fail++;
          $display("FAIL %s stall_cycles: got %0d want %0d", e.name, stall_cycles, e.cycles);
        end
      end
    end
  end

  task automatic idle();
    reset       = 1'b0;
    id_valid    = 1'b0;
    id_rs1      = '0;
    id_rs2      = '0;
    id_rs1_used = 1'b0;
    id_rs2_used = 1'b0;
    id_is_md    = 1'b0;
    ex_valid    = 1'b0;
    ex_mem_read = 1'b0;
    ex_rd       = '0;
    md_issue    = 1'b0;
    md_rd       = '0;
    md_done     = 1'b0;
    flush       = 1'b0;
  endtask

  // Queue the hand-computed response for the inputs currently driven, then
  // advance one cycle. The counter expectation follows the saturating rule.
  task automatic step(input logic [1:0] cause, input logic busy, input string name);
    exp_t e;
    e.name   = name;
    e.cause  = cause;
    e.stall  = (cause != 2'b00);
    e.busy   = busy;
`ifdef STALL_PERF_EN
    e.cycles = exp_cnt;
    if (reset) exp_cnt = '0;
    else if (e.stall && exp_cnt != 4'd15) exp_cnt = exp_cnt + 4'd1;
`else
    e.cycles = '0;
`endif
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic load_use_rs1(input logic [AW-1:0] r);
    id_valid = 1'b1; id_rs1 = r; id_rs1_used = 1'b1;
    ex_valid = 1'b1; ex_mem_read = 1'b1; ex_rd = r;
  endtask

  initial begin
    idle();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    idle(); reset = 1'b1;                              step(2'b00, 1'b0, "reset_state");
    idle(); load_use_rs1(5'd5);                        step(2'b01, 1'b0, "lu_rs1");
    idle(); load_use_rs1(5'd0);                        step(2'b00, 1'b0, "lu_x0_exempt");
    idle(); load_use_rs1(5'd5); id_rs1_used = 1'b0;
            id_rs2 = 5'd5; id_rs2_used = 1'b1;         step(2'b01, 1'b0, "lu_rs2");
    idle(); load_use_rs1(5'd5); id_rs1_used = 1'b0;    step(2'b00, 1'b0, "lu_not_used");
    idle(); load_use_rs1(5'd5); ex_mem_read = 1'b0;    step(2'b00, 1'b0, "ex_not_load");
    idle(); load_use_rs1(5'd5); ex_valid = 1'b0;       step(2'b00, 1'b0, "ex_not_valid");

    idle(); md_issue = 1'b1; md_rd = 5'd7;             step(2'b00, 1'b0, "md_issue7");
    idle(); id_valid = 1'b1; id_rs2 = 5'd7; id_rs2_used = 1'b1;
                                                       step(2'b10, 1'b1, "raw7_a");
    idle(); id_valid = 1'b1; id_rs2 = 5'd7; id_rs2_used = 1'b1;
                                                       step(2'b10, 1'b1, "raw7_b");
    idle(); id_valid = 1'b1; id_rs2 = 5'd7; id_rs2_used = 1'b1; md_done = 1'b1;
                                                       step(2'b00, 1'b1, "raw7_done");
    idle(); id_valid = 1'b1; id_rs2 = 5'd7; id_rs2_used = 1'b1;
                                                       step(2'b00, 1'b0, "after_done");

    idle(); md_issue = 1'b1; md_rd = 5'd3;             step(2'b00, 1'b0, "md_issue3");
    idle(); id_valid = 1'b1; id_is_md = 1'b1;          step(2'b11, 1'b1, "md_struct");
    idle(); id_valid = 1'b1; id_is_md = 1'b1; id_rs1 = 5'd3; id_rs1_used = 1'b1;
                                                       step(2'b10, 1'b1, "raw_over_struct");
    idle(); md_done = 1'b1; md_issue = 1'b1; md_rd = 5'd9;
                                                       step(2'b00, 1'b1, "done_issue9");
    idle(); id_valid = 1'b1; id_rs1 = 5'd9; id_rs1_used = 1'b1;
                                                       step(2'b10, 1'b1, "tag9");
    idle(); id_valid = 1'b1; id_rs1 = 5'd3; id_rs1_used = 1'b1;
                                                       step(2'b00, 1'b1, "old_tag3_gone");
    idle(); load_use_rs1(5'd9);                        step(2'b01, 1'b1, "lu_over_raw");
    idle(); load_use_rs1(5'd9); flush = 1'b1;          step(2'b00, 1'b1, "flush_kills");
    idle(); id_valid = 1'b1; id_is_md = 1'b1;          step(2'b11, 1'b1, "busy_after_flush");
    idle(); id_rs1 = 5'd9; id_rs1_used = 1'b1;         step(2'b00, 1'b1, "id_invalid");
    idle(); reset = 1'b1; md_issue = 1'b1; md_rd = 5'd4;
                                                       step(2'b00, 1'b1, "reset_mid_op");
    idle(); id_valid = 1'b1; id_rs1 = 5'd4; id_rs1_used = 1'b1;
            id_rs2 = 5'd9; id_rs2_used = 1'b1;         step(2'b00, 1'b0, "after_reset");
    idle(); md_issue = 1'b1; md_rd = 5'd0;             step(2'b00, 1'b0, "issue_x0");
    idle(); id_valid = 1'b1; id_is_md = 1'b1; id_rs1_used = 1'b1;
                                                       step(2'b00, 1'b0, "x0_untracked");

    for (int i = 0; i < 20; i++) begin
      idle(); load_use_rs1(5'd12);                     step(2'b01, 1'b0, "sat_run");
    end
    idle();                                            step(2'b00, 1'b0, "sat_final");

    for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
